// File: rtl/svi_force_pkg.sv
// Shared types for the SVI force scheduler: command opcodes, FSM states and
// the pending global-event encoding.
package svi_force_pkg;

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_FORCE   = 2'b01,
        OP_RELEASE = 2'b10
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_APPLY,
        S_ACK
    } state_e;

    typedef enum logic [1:0] {
        EVT_NONE,
        EVT_ALL_F,
        EVT_ALL_R
    } evt_e;

    // Raw 2'b11 carries no meaning and folds into NOP.
    function automatic op_e decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return OP_FORCE;
            2'b10:   return OP_RELEASE;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/svi_rr_arb.sv
// Combinational round-robin arbiter: the lowest-numbered valid requester at or
// after the pointer wins; outputs both one-hot and binary grant.
module svi_rr_arb #(
    parameter  int NREQ = 4,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   gnt_idx
);

    logic          found;
    logic [PW-1:0] slot;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        slot    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            slot = PW'((32'(ptr) + i) % NREQ);
            if (!found && req_valid[slot]) begin
                found     = 1'b1;
                gnt[slot] = 1'b1;
                gnt_idx   = slot;
            end
        end
    end

endmodule

// File: rtl/svi_force_sched.sv
// Force/release scheduler for an array of interface signals: round-robin command
// arbitration, a 4-state command FSM, and en edge-triggered force-all/release-all.
module svi_force_sched
    import svi_force_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    localparam int IDXW = (N > 1) ? $clog2(N) : 1,
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 en_val,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [IDXW*NREQ-1:0] req_idx,
    input  logic [NREQ-1:0]      req_val,
    output logic [NREQ-1:0]      req_ready,
    output logic [N-1:0]         force_mask,
    output logic [N-1:0]         force_val,
    output logic                 busy,
    output logic                 err
);

    state_e          state_q;
    evt_e            evt_q;
    logic            en_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   g_q;
    logic [NREQ-1:0] g_oh_q;
    logic [1:0]      raw_op_q;
    op_e             op_q;
    logic [IDXW-1:0] idx_q;
    logic            val_q;
    logic            bad_q;
    logic [N-1:0]    mask_q;
    logic [N-1:0]    fval_q;
    logic [NREQ-1:0] ready_q;
    logic            err_q;

    logic            rise;
    logic            fall;
    logic [NREQ-1:0] gnt;
    logic [PW-1:0]   gnt_idx;

    assign rise = en & ~en_q;
    assign fall = ~en & en_q;

    svi_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            evt_q    <= EVT_NONE;
            en_q     <= 1'b0;
            ptr_q    <= '0;
            g_q      <= '0;
            g_oh_q   <= '0;
            raw_op_q <= '0;
            op_q     <= OP_NOP;
            idx_q    <= '0;
            val_q    <= 1'b0;
            bad_q    <= 1'b0;
            mask_q   <= '0;
            fval_q   <= '0;
            ready_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            en_q <= en;
            case (state_q)
                S_IDLE: begin
                    if (evt_q == EVT_ALL_F) begin
                        mask_q <= '1;
                        fval_q <= {N{en_val}};
                        evt_q  <= EVT_NONE;
                    end else if (evt_q == EVT_ALL_R) begin
                        mask_q <= '0;
                        evt_q  <= EVT_NONE;
                    end else if (|req_valid) begin
                        g_q      <= gnt_idx;
                        g_oh_q   <= gnt;
                        raw_op_q <= req_op[2*int'(gnt_idx) +: 2];
                        idx_q    <= req_idx[IDXW*int'(gnt_idx) +: IDXW];
                        val_q    <= req_val[gnt_idx];
                        state_q  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    op_q    <= decode_op(raw_op_q);
                    bad_q   <= (decode_op(raw_op_q) == OP_NOP) || (32'(idx_q) >= N);
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    if (!bad_q) begin
                        if (op_q == OP_FORCE) begin
                            mask_q[idx_q] <= 1'b1;
                            fval_q[idx_q] <= val_q;
                        end else if (op_q == OP_RELEASE) begin
                            mask_q[idx_q] <= 1'b0;
                        end
                    end
                    ready_q <= g_oh_q;
                    err_q   <= bad_q;
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    ready_q <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= (g_q == PW'(NREQ-1)) ? '0 : g_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // Placed after the FSM so a fresh edge overrides the IDLE-side clear.
            if (rise) begin
                evt_q <= EVT_ALL_F;
            end else if (fall) begin
                evt_q <= EVT_ALL_R;
            end
        end
    end

    assign req_ready  = ready_q;
    assign force_mask = mask_q;
    assign force_val  = fval_q;
    assign busy       = (state_q != S_IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_svi_force_sched.sv
// Bench for svi_force_sched: directed scenarios plus randomized command traffic,
// checked against a behavioural model of grant order, mask and values.
`timescale 1ns/1ps
module tb_svi_force_sched;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int IDXW = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 en_val = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [2*NREQ-1:0]    req_op = '0;
    logic [IDXW*NREQ-1:0] req_idx = '0;
    logic [NREQ-1:0]      req_val = '0;
    logic [NREQ-1:0]      req_ready;
    logic [N-1:0]         force_mask;
    logic [N-1:0]         force_val;
    logic                 busy;
    logic                 err;

    int tests = 0;
    int fails = 0;

    // Behavioural model: array state, RR pointer, outstanding commands.
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] m_val = '0;
    int           m_ptr = 0;
    bit           pend[NREQ];
    logic [1:0]   p_op[NREQ];
    int           p_idx[NREQ];
    logic         p_val[NREQ];

    typedef struct {
        logic [NREQ-1:0] rdy, exp_rdy;
        logic            er, exp_er;
        logic [N-1:0]    mask, exp_mask, fv, exp_fv;
        int              cyc, exp_cyc;
    } grant_t;
    grant_t log_q[$];
    bit     run_to;

    always #5 clk = ~clk;

    svi_force_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .en_val     (en_val),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_idx    (req_idx),
        .req_val    (req_val),
        .req_ready  (req_ready),
        .force_mask (force_mask),
        .force_val  (force_val),
        .busy       (busy),
        .err        (err)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit any_pend();
        for (int k = 0; k < NREQ; k++) if (pend[k]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int predict();
        int j;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (pend[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic cmd_invalid(input int w);
        return !(p_op[w] == 2'b01 || p_op[w] == 2'b10) || p_idx[w] >= N;
    endfunction

    task automatic model_apply(input int w);
        if (!cmd_invalid(w)) begin
            if (p_op[w] == 2'b01) begin
                m_mask[p_idx[w]] = 1'b1;
                m_val[p_idx[w]]  = p_val[w];
            end else begin
                m_mask[p_idx[w]] = 1'b0;
            end
        end
    endtask

    task automatic post(input int r, input logic [1:0] op, input int idx, input logic val);
        pend[r] = 1'b1; p_op[r] = op; p_idx[r] = idx; p_val[r] = val;
        req_op[2*r +: 2]        = op;
        req_idx[IDXW*r +: IDXW] = IDXW'(idx);
        req_val[r]              = val;
        req_valid[r]            = 1'b1;
    endtask

    // Requesters hold their command until they see ready; each grant is logged with the model's expectation.
    task automatic run_cmds(input int budget);
        int     cyc;
        int     prev;
        int     w;
        grant_t g;
        cyc = 0; prev = -1; run_to = 1'b0;
        log_q.delete();
        while (any_pend() && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (req_ready !== '0) begin
                w = predict();
                g.rdy = req_ready; g.exp_rdy = '0;
                if (w >= 0) g.exp_rdy[w] = 1'b1;
                g.er = err; g.exp_er = (w >= 0) ? cmd_invalid(w) : 1'b0;
                g.cyc = cyc; g.exp_cyc = (prev < 0) ? 3 : prev + 4;
                prev = cyc;
                if (w >= 0) model_apply(w);
                g.mask = force_mask; g.exp_mask = m_mask;
                g.fv = force_val & m_mask; g.exp_fv = m_val & m_mask;
                log_q.push_back(g);
                if (w >= 0) begin
                    pend[w] = 1'b0; req_valid[w] = 1'b0;
                    m_ptr = (w + 1) % NREQ;
                end
            end
        end
        if (any_pend()) run_to = 1'b1;
        for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; en_val = 1'b1;
        req_valid = '1; req_op = 8'h55; req_idx = 12'h688;
        repeat (3) @(negedge clk);
        tests++;
        if ({force_mask, req_ready, busy, err} !== '0) begin
            fails++;
            $display("FAIL reset_state: mask/ready/busy/err = %h/%b/%b/%b want 0", force_mask, req_ready, busy, err);
        end
        req_valid = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (force_mask !== '0) begin
            fails++; $display("FAIL reset_first_clk: mask=%h want 00", force_mask);
        end
        @(negedge clk);
        m_mask = '1; m_val = '1;
        tests++;
        if ({force_mask, force_val} !== {m_mask, m_val}) begin
            fails++; $display("FAIL reset_en_rise: mask/val=%h/%h want %h/%h", force_mask, force_val, m_mask, m_val);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        m_mask = '0;
        tests++;
        if ({force_mask, busy} !== {m_mask, 1'b0}) begin
            fails++; $display("FAIL reset_en_fall: mask=%h busy=%b want %h/0", force_mask, busy, m_mask);
        end
    endtask

    task automatic test_round_robin();
        @(negedge clk);
        for (int r = 0; r < NREQ; r++) post(r, 2'b01, r, $urandom_range(0, 1));
        run_cmds(40);
        tests++;
        if (run_to || log_q.size() != NREQ) begin
            fails++; $display("FAIL rr_count: grants=%0d timeout=%0b want %0d/0", log_q.size(), run_to, NREQ);
        end
        foreach (log_q[k]) begin
            tests++;
            if ({log_q[k].rdy, log_q[k].er, log_q[k].mask, log_q[k].fv} !== {log_q[k].exp_rdy, log_q[k].exp_er, log_q[k].exp_mask, log_q[k].exp_fv}) begin
                fails++; $display("FAIL rr_grant%0d: rdy/err/mask/val=%b/%b/%h/%h want %b/%b/%h/%h", k, log_q[k].rdy, log_q[k].er, log_q[k].mask, log_q[k].fv, log_q[k].exp_rdy, log_q[k].exp_er, log_q[k].exp_mask, log_q[k].exp_fv);
            end
            tests++;
            if (log_q[k].cyc != log_q[k].exp_cyc) begin
                fails++; $display("FAIL rr_timing%0d: ready at cycle %0d want %0d", k, log_q[k].cyc, log_q[k].exp_cyc);
            end
        end
        tests++;
        if (force_mask !== 8'h0F) begin
            fails++; $display("FAIL rr_final_mask: %h want 0f", force_mask);
        end
    endtask

    task automatic test_global_edges();
        @(negedge clk);
        en_val = 1'b1; en = 1'b1;
        @(negedge clk);
        tests++;
        if (force_mask !== m_mask) begin
            fails++; $display("FAIL edge_early: mask=%h want %h", force_mask, m_mask);
        end
        @(negedge clk);
        m_mask = '1; m_val = '1;
        tests++;
        if ({force_mask, force_val} !== {m_mask, m_val}) begin
            fails++; $display("FAIL edge_force_all: mask/val=%h/%h want %h/%h", force_mask, force_val, m_mask, m_val);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        m_mask = '0;
        tests++;
        if (force_mask !== m_mask) begin
            fails++; $display("FAIL edge_release_all: mask=%h want %h", force_mask, m_mask);
        end
        en_val = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        m_mask = '1; m_val = '0;
        tests++;
        if ({force_mask, force_val} !== {m_mask, m_val}) begin
            fails++; $display("FAIL edge_force_zero: mask/val=%h/%h want %h/%h", force_mask, force_val, m_mask, m_val);
        end
        en = 1'b0;
        repeat (2) @(negedge clk);
        m_mask = '0;
    endtask

    task automatic test_commands();
        logic [1:0] ops[7]  = '{2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b10};
        int         idxs[7] = '{3, 3, 6, 5, 1, 6, 2};
        int         reqs[7] = '{0, 0, 1, 2, 3, 2, 1};
        logic       vals[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            post(reqs[c], ops[c], idxs[c], vals[c]);
            run_cmds(20);
            tests++;
            if (run_to || log_q.size() != 1) begin
                fails++; $display("FAIL cmd%0d_count: grants=%0d timeout=%0b want 1/0", c, log_q.size(), run_to);
            end
            foreach (log_q[k]) begin
                tests++;
                if ({log_q[k].rdy, log_q[k].er, log_q[k].mask, log_q[k].fv} !== {log_q[k].exp_rdy, log_q[k].exp_er, log_q[k].exp_mask, log_q[k].exp_fv}) begin
                    fails++; $display("FAIL cmd%0d: rdy/err/mask/val=%b/%b/%h/%h want %b/%b/%h/%h", c, log_q[k].rdy, log_q[k].er, log_q[k].mask, log_q[k].fv, log_q[k].exp_rdy, log_q[k].exp_er, log_q[k].exp_mask, log_q[k].exp_fv);
                end
                tests++;
                if (log_q[k].cyc != 3) begin
                    fails++; $display("FAIL cmd%0d_latency: ready at cycle %0d want 3", c, log_q[k].cyc);
                end
            end
            if (c == 0) begin
                tests++;
                if ({force_mask, force_val[3]} !== {8'h08, 1'b1}) begin
                    fails++; $display("FAIL single_force: mask=%h val3=%b want 08/1", force_mask, force_val[3]);
                end
            end
        end
    endtask

    task automatic test_edge_while_busy();
        int              w;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        post(1, 2'b01, 2, 1'b1);
        @(negedge clk); en_val = 1'b1; en = 1'b1;
        @(negedge clk); en = 1'b0;
        @(negedge clk);
        w = predict();
        exp_rdy = '0;
        if (w >= 0) begin
            exp_rdy[w] = 1'b1;
            model_apply(w);
            pend[w] = 1'b0;
            m_ptr = (w + 1) % NREQ;
        end
        tests++;
        if ({req_ready, err, force_mask} !== {exp_rdy, 1'b0, m_mask}) begin
            fails++; $display("FAIL busy_edge_ack: rdy/err/mask=%b/%b/%h want %b/0/%h", req_ready, err, force_mask, exp_rdy, m_mask);
        end
        req_valid = '0;
        @(negedge clk);
        tests++;
        if ({busy, force_mask} !== {1'b0, m_mask}) begin
            fails++; $display("FAIL busy_edge_hold: busy/mask=%b/%h want 0/%h", busy, force_mask, m_mask);
        end
        @(negedge clk);
        m_mask = '0;
        tests++;
        if (force_mask !== m_mask) begin
            fails++; $display("FAIL busy_edge_release: mask=%h want %h", force_mask, m_mask);
        end
    endtask

    task automatic test_random();
        int  n;
        int  sel;
        for (int it = 0; it < 25; it++) begin
            @(negedge clk);
            n = 0;
            for (int r = 0; r < NREQ; r++) begin
                if ($urandom_range(0, 2) != 0 || (r == NREQ-1 && n == 0)) begin
                    sel = $urandom_range(0, 9);
                    post(r, (sel < 5) ? 2'b01 : (sel < 8) ? 2'b10 : (sel == 8) ? 2'b00 : 2'b11,
                         $urandom_range(0, N-1), 1'($urandom_range(0, 1)));
                    n++;
                end
            end
            run_cmds(60);
            tests++;
            if (run_to || log_q.size() != n) begin
                fails++; $display("FAIL rand%0d_count: grants=%0d timeout=%0b want %0d/0", it, log_q.size(), run_to, n);
            end
            foreach (log_q[k]) begin
                tests++;
                if ({log_q[k].rdy, log_q[k].er, log_q[k].mask, log_q[k].fv} !== {log_q[k].exp_rdy, log_q[k].exp_er, log_q[k].exp_mask, log_q[k].exp_fv}) begin
                    fails++; $display("FAIL rand%0d_grant%0d: rdy/err/mask/val=%b/%b/%h/%h want %b/%b/%h/%h", it, k, log_q[k].rdy, log_q[k].er, log_q[k].mask, log_q[k].fv, log_q[k].exp_rdy, log_q[k].exp_er, log_q[k].exp_mask, log_q[k].exp_fv);
                end
                tests++;
                if (log_q[k].cyc != log_q[k].exp_cyc) begin
                    fails++; $display("FAIL rand%0d_timing%0d: ready at cycle %0d want %0d", it, k, log_q[k].cyc, log_q[k].exp_cyc);
                end
            end
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        @(negedge clk);
        post(3, 2'b01, 7, 1'b1);
        post(0, 2'b01, 0, 1'b1);
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL midop_busy: busy=%b want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({req_ready, force_mask, busy, err} !== '0) begin
            fails++; $display("FAIL midop_reset: rdy/mask/busy/err=%b/%h/%b/%b want 0", req_ready, force_mask, busy, err);
        end
        req_valid = '0;
        for (int k = 0; k < NREQ; k++) pend[k] = 1'b0;
        m_mask = '0; m_ptr = 0;
        @(negedge clk); rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (req_ready !== '0) seen = 1'b1;
        end
        tests++;
        if ({seen, force_mask, busy} !== {1'b0, m_mask, 1'b0}) begin
            fails++; $display("FAIL midop_after: ready_seen/mask/busy=%b/%h/%b want 0/%h/0", seen, force_mask, busy, m_mask);
        end
        @(negedge clk);
        post(1, 2'b01, 5, 1'b1);
        post(2, 2'b01, 4, 1'b0);
        run_cmds(30);
        tests++;
        if (run_to || log_q.size() != 2) begin
            fails++; $display("FAIL midop_ptr_count: grants=%0d timeout=%0b want 2/0", log_q.size(), run_to);
        end
        foreach (log_q[k]) begin
            tests++;
            if ({log_q[k].rdy, log_q[k].mask} !== {log_q[k].exp_rdy, log_q[k].exp_mask}) begin
                fails++; $display("FAIL midop_ptr%0d: rdy/mask=%b/%h want %b/%h", k, log_q[k].rdy, log_q[k].mask, log_q[k].exp_rdy, log_q[k].exp_mask);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) begin
            pend[k] = 1'b0; p_op[k] = 2'b00; p_idx[k] = 0; p_val[k] = 1'b0;
        end
        test_reset();
        test_round_robin();
        test_global_edges();
        test_commands();
        test_edge_while_busy();
        test_random();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
